// File: rtl/soc_system_pio_pkg.sv
// Shared definitions for the debounced Avalon-MM input PIO: register map,
// edge-capture modes and the debounce counter width helper.
package soc_system_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RAW     = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } reg_addr_e;

    typedef enum int unsigned {
        EDGE_RISING  = 0,
        EDGE_FALLING = 1,
        EDGE_ANY     = 2
    } edge_type_e;

    localparam int unsigned BUS_WIDTH = 32;

    // Counter must hold 0..cycles; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/soc_system_debounced_pio_in_if.sv
// Avalon-MM slave bus of the debounced input PIO (lightweight HPS-to-FPGA bridge).
interface soc_system_debounced_pio_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/soc_system_debounce_bit.sv
// One input bit: multi-flop synchroniser followed by a persistence filter that
// only accepts a new level after it has held for DEBOUNCE_CYCLES cycles.
module soc_system_debounce_bit
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic stable
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = chain[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable <= 1'b0;
                end else begin
                    stable <= sync;
                end
            end
        end else begin : g_filter
            localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt;

            // Any return to the accepted level restarts the persistence count.
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable <= 1'b0;
                    cnt    <= '0;
                end else if (sync == stable) begin
                    cnt <= '0;
                end else if (cnt == LAST) begin
                    stable <= sync;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/soc_system_debounced_pio_in.sv
// Debounced WIDTH-bit input PIO: per-bit filters, edge capture with W1C,
// interrupt mask, registered read mux and level irq.
module soc_system_debounced_pio_in
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    soc_system_debounced_pio_in_if.slave  avs,
    input  logic [WIDTH-1:0]              in_port,
    output logic                          irq
);

    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] wr_clear;
    logic             wr_en;
    logic [31:0]      rd_next;
    logic             unused_wdata;

    generate
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            soc_system_debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_bit (
                .clk    (clk),
                .reset  (reset),
                .din    (in_port[i]),
                .sync   (sync[i]),
                .stable (stable[i])
            );
        end
    endgenerate

    assign wr_en        = avs.chipselect & avs.write;
    assign unused_wdata = ^avs.writedata;

    always_comb begin
        edge_evt = '0;
        if (EDGE_TYPE == EDGE_RISING) begin
            edge_evt = stable & ~stable_d;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            edge_evt = ~stable & stable_d;
        end else begin
            edge_evt = stable ^ stable_d;
        end
    end

    always_comb begin
        wr_clear = '0;
        if (wr_en && avs.address == ADDR_EDGECAP) begin
            wr_clear = avs.writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_next = '0;
        case (avs.address)
            ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
            ADDR_RAW:     rd_next[WIDTH-1:0] = sync;
            ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
            ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
            default:      rd_next = '0;
        endcase
    end

    // Set is ORed after the clear so a same-cycle event survives a W1C write.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d     <= '0;
            edgecap      <= '0;
            irqmask      <= '0;
            avs.readdata <= '0;
        end else begin
            stable_d     <= stable;
            edgecap      <= (edgecap & ~wr_clear) | edge_evt;
            avs.readdata <= rd_next;
            if (wr_en && avs.address == ADDR_IRQMASK) begin
                irqmask <= avs.writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_soc_system_debounced_pio_in.sv
// Scoreboard bench: four PIO variants (rising/falling/any edge with a 4-cycle
// filter, any edge with the filter bypassed) share one stimulus stream.
module tb_soc_system_debounced_pio_in;

    localparam int SYNC = 2;
    localparam int NK   = 4;
    localparam int DBK [NK] = '{4, 4, 4, 0};
    localparam int ETK [NK] = '{0, 1, 2, 2};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  in_port = '0;
    logic [31:0] rd [NK];
    logic        irqv [NK];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    soc_system_debounced_pio_in_if bus0 ();
    soc_system_debounced_pio_in_if bus1 ();
    soc_system_debounced_pio_in_if bus2 ();
    soc_system_debounced_pio_in_if bus3 ();

    assign bus0.address = address; assign bus0.chipselect = chipselect;
    assign bus0.write = write;     assign bus0.writedata = writedata;
    assign bus1.address = address; assign bus1.chipselect = chipselect;
    assign bus1.write = write;     assign bus1.writedata = writedata;
    assign bus2.address = address; assign bus2.chipselect = chipselect;
    assign bus2.write = write;     assign bus2.writedata = writedata;
    assign bus3.address = address; assign bus3.chipselect = chipselect;
    assign bus3.write = write;     assign bus3.writedata = writedata;
    assign rd[0] = bus0.readdata;
    assign rd[1] = bus1.readdata;
    assign rd[2] = bus2.readdata;
    assign rd[3] = bus3.readdata;

    soc_system_debounced_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0))
        dut0 (.clk(clk), .reset(reset), .avs(bus0), .in_port(in_port), .irq(irqv[0]));
    soc_system_debounced_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1))
        dut1 (.clk(clk), .reset(reset), .avs(bus1), .in_port(in_port), .irq(irqv[1]));
    soc_system_debounced_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2))
        dut2 (.clk(clk), .reset(reset), .avs(bus2), .in_port(in_port), .irq(irqv[2]));
    soc_system_debounced_pio_in #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2))
        dut3 (.clk(clk), .reset(reset), .avs(bus3), .in_port(in_port), .irq(irqv[3]));

    // Reference model: a level is accepted once the last DB synchronised
    // samples all disagree with the accepted level.
    logic [3:0]  sp [SYNC];
    logic [3:0]  m_stable [NK];
    logic [3:0]  m_prev [NK];
    logic [3:0]  m_cap [NK];
    logic [3:0]  m_mask [NK];
    logic [3:0]  win [NK][$];
    logic [32:0] expq [NK][$];

    always @(posedge clk) begin
        logic [3:0]  s_old;
        logic [3:0]  ev;
        logic [3:0]  clr;
        logic [3:0]  nst;
        logic [31:0] r;
        bit          all;
        s_old = sp[SYNC-1];
        if (reset) begin
            for (int i = 0; i < SYNC; i++) sp[i] = '0;
            for (int k = 0; k < NK; k++) begin
                m_stable[k] = '0; m_prev[k] = '0; m_cap[k] = '0; m_mask[k] = '0;
                win[k].delete();
                expq[k].push_back(33'd0);
            end
        end else begin
            for (int k = 0; k < NK; k++) begin
                r = '0;
                case (address)
                    2'd0: r[3:0] = m_stable[k];
                    2'd1: r[3:0] = s_old;
                    2'd2: r[3:0] = m_mask[k];
                    default: r[3:0] = m_cap[k];
                endcase
                if (ETK[k] == 0)      ev = m_stable[k] & ~m_prev[k];
                else if (ETK[k] == 1) ev = ~m_stable[k] & m_prev[k];
                else                  ev = m_stable[k] ^ m_prev[k];
                clr = (chipselect && write && address == 2'd3) ? writedata[3:0] : 4'h0;
                m_cap[k] = (m_cap[k] & ~clr) | ev;
                if (chipselect && write && address == 2'd2) m_mask[k] = writedata[3:0];
                m_prev[k] = m_stable[k];
                if (DBK[k] == 0) begin
                    nst = s_old;
                end else begin
                    nst = m_stable[k];
                    win[k].push_back(s_old);
                    if (win[k].size() > DBK[k]) void'(win[k].pop_front());
                    for (int b = 0; b < 4; b++) begin
                        all = (win[k].size() == DBK[k]);
                        foreach (win[k][j]) if (win[k][j][b] == m_stable[k][b]) all = 0;
                        if (all) nst[b] = ~m_stable[k][b];
                    end
                end
                m_stable[k] = nst;
                expq[k].push_back({|(m_cap[k] & m_mask[k]), r});
            end
            for (int i = SYNC - 1; i > 0; i--) sp[i] = sp[i-1];
            sp[0] = in_port;
        end
    end

    // Monitor: readdata and irq are presented every cycle.
    always @(posedge clk) begin
        logic [32:0] e;
        #1;
        for (int k = 0; k < NK; k++) begin
            checks++;
            if (expq[k].size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty dut%0d at %0t", k, $time);
            end else begin
                e = expq[k].pop_front();
                if (rd[k] !== e[31:0] || irqv[k] !== e[32]) begin
                    errors++;
                    $display("FAIL rd_irq dut%0d at %0t addr=%0d: got rd=%h irq=%b, want rd=%h irq=%b",
                             k, $time, address, rd[k], irqv[k], e[31:0], e[32]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic scan(input int n);
        for (int i = 0; i < n; i++) begin
            address = 2'(i);
            @(negedge clk);
        end
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        scan(8);
        // bit0 rises and is held
        in_port[0] = 1'b1;
        scan(12);
        // bit1 glitch shorter than the filter
        in_port[1] = 1'b1;
        tick(3);
        in_port[1] = 1'b0;
        scan(10);
        bus_wr(2'd2, 32'hFFFF_FFF1);
        scan(4);
        bus_wr(2'd3, 32'h1);
        scan(4);
        // bit0 falls; W1C lands on the same edge the new event is captured
        in_port[0] = 1'b0;
        tick(6);
        bus_wr(2'd3, 32'h1);
        scan(8);
        // bit2 rises then falls for the edge-type variants
        in_port[2] = 1'b1;
        scan(12);
        in_port[2] = 1'b0;
        scan(12);
        // writes with chipselect low and to read-only addresses are ignored
        address = 2'd2; writedata = 32'h0; write = 1'b1;
        tick(1);
        write = 1'b0;
        bus_wr(2'd0, 32'hF);
        bus_wr(2'd1, 32'hF);
        scan(4);
        // reset mid-count with bit3 held high
        in_port[3] = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        scan(12);
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 5) == 0) in_port[b] = ~in_port[b];
            address    = 2'($urandom_range(0, 3));
            chipselect = ($urandom_range(0, 1) == 1);
            write      = ($urandom_range(0, 3) == 0);
            writedata  = $urandom;
            reset      = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        reset = 1'b0; chipselect = 1'b0; write = 1'b0;
        scan(8);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
